// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter
//
// Shares one SDRAM master command port between a read client (playback
// fetcher) and a write client (DSP writeback). One command is in flight on
// the command port at a time. It is held on the registered TL_* outputs
// until the memory accepts it, which happens when MEM_WAITREQ is low. The
// number of reads accepted but not yet returned is bounded by MAX_RD_OUT.
// A pending write is forced through after WR_STARVE consecutive read grants.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   RD_REQ/RD_ADDR        read request (held until RD_ACK) and word address
//   RD_ACK                read command accepted this cycle (combinational)
//   RD_DATA/RD_VALID      returned read word, one cycle after TL_RDV
//   WR_REQ/WR_ADDR/WR_DATA write request (held until WR_ACK), address, sample
//   WR_ACK                write command accepted this cycle (combinational)
//   TL_ADDR/TL_READ/TL_WRITE/TL_WRITEDATA  registered command to the master
//   TL_READDATA/TL_RDV    read return from the master
//   MEM_WAITREQ           memory stall; low at an edge means command accepted
module sdram_access_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_RD_OUT = 4,
    parameter int WR_STARVE  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_ACK,
    output logic [31:0]       RD_DATA,
    output logic              RD_VALID,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [15:0]       WR_DATA,
    output logic              WR_ACK,
    output logic [ADDR_W-1:0] TL_ADDR,
    output logic              TL_READ,
    output logic              TL_WRITE,
    output logic [15:0]       TL_WRITEDATA,
    input  logic [31:0]       TL_READDATA,
    input  logic              TL_RDV,
    input  logic              MEM_WAITREQ
);

    localparam int SW = (WR_STARVE < 1) ? 1 : $clog2(WR_STARVE + 1);
    localparam logic [3:0]    RD_LIMIT   = 4'(MAX_RD_OUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_ISSUE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    rd_out_reg, rd_out_next;
    logic [SW-1:0] starve_reg, starve_next;

    logic rd_ok;
    logic rd_grant;
    logic wr_grant;
    logic rd_accept;
    logic wr_accept;
    logic rd_ret;

    assign rd_ok     = RD_REQ && (rd_out_reg < RD_LIMIT);
    assign rd_accept = (state_reg == RD_ISSUE) && !MEM_WAITREQ;
    assign wr_accept = (state_reg == WR_ISSUE) && !MEM_WAITREQ;
    // A return with nothing outstanding is a stale one from before reset.
    assign rd_ret    = TL_RDV && (rd_out_reg != 4'd0);

    // Reset drops an in-flight command, so no acknowledge may escape while
    // it is asserted.
    assign RD_ACK = rd_accept && !RESET;
    assign WR_ACK = wr_accept && !RESET;

    always_comb begin
        state_next = state_reg;
        rd_grant   = 1'b0;
        wr_grant   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (WR_REQ && ((starve_reg == STARVE_MAX) || !rd_ok)) begin
                    state_next = WR_ISSUE;
                    wr_grant   = 1'b1;
                end else if (rd_ok) begin
                    state_next = RD_ISSUE;
                    rd_grant   = 1'b1;
                end
            end
            RD_ISSUE: if (!MEM_WAITREQ) state_next = IDLE;
            WR_ISSUE: if (!MEM_WAITREQ) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_out_next = rd_out_reg;
        if (rd_accept && !rd_ret) begin
            rd_out_next = rd_out_reg + 4'd1;
        end else if (!rd_accept && rd_ret) begin
            rd_out_next = rd_out_reg - 4'd1;
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (wr_grant) begin
            starve_next = '0;
        end else if (rd_grant && WR_REQ && (starve_reg != STARVE_MAX)) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            TL_READ      <= 1'b0;
            TL_WRITE     <= 1'b0;
            TL_ADDR      <= '0;
            TL_WRITEDATA <= '0;
            RD_DATA      <= '0;
            RD_VALID     <= 1'b0;
            rd_out_reg   <= '0;
            starve_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            TL_READ    <= (state_next == RD_ISSUE);
            TL_WRITE   <= (state_next == WR_ISSUE);
            // Address and data are captured only on entry to an issue state
            // so they stay frozen while the memory stalls.
            if (rd_grant) begin
                TL_ADDR <= RD_ADDR;
            end
            if (wr_grant) begin
                TL_ADDR      <= WR_ADDR;
                TL_WRITEDATA <= WR_DATA;
            end
            RD_DATA    <= TL_READDATA;
            RD_VALID   <= rd_ret;
            rd_out_reg <= rd_out_next;
            starve_reg <= starve_next;
        end
    end

endmodule
